// File: rtl/ps2_move_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, tracks E0/F0 prefixes
// and maps arrow/WASD make codes onto the snake move encoding (0=R,1=U,2=L,3=D).
module ps2_move_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10_000
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [1:0] move,
    output logic       move_valid
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic [FW-1:0] r_fcnt;
    logic          r_filt, r_filt_q;
    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tocnt;
    logic          r_ext, r_brk;

    logic          w_fall;
    logic          w_dec_hit;
    logic [1:0]    w_dec_move;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_c_s1   <= 1'b1;
            r_c_s2   <= 1'b1;
            r_d_s1   <= 1'b1;
            r_d_s2   <= 1'b1;
            r_fcnt   <= '0;
            r_filt   <= 1'b1;
            r_filt_q <= 1'b1;
        end else begin
            r_c_s1   <= ps2c;
            r_c_s2   <= r_c_s1;
            r_d_s1   <= ps2d;
            r_d_s2   <= r_d_s1;
            r_filt_q <= r_filt;
            // r_fcnt counts consecutive samples that disagree with the filtered level
            if (r_c_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_filt <= r_c_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_fall = r_filt_q & ~r_filt;

    always_comb begin
        w_dec_hit  = 1'b0;
        w_dec_move = 2'd0;
        if (r_ext) begin
            case (r_shift)
                8'h74:   begin w_dec_hit = 1'b1; w_dec_move = 2'd0; end
                8'h75:   begin w_dec_hit = 1'b1; w_dec_move = 2'd1; end
                8'h6B:   begin w_dec_hit = 1'b1; w_dec_move = 2'd2; end
                8'h72:   begin w_dec_hit = 1'b1; w_dec_move = 2'd3; end
                default: ;
            endcase
        end else begin
            case (r_shift)
                8'h23:   begin w_dec_hit = 1'b1; w_dec_move = 2'd0; end
                8'h1D:   begin w_dec_hit = 1'b1; w_dec_move = 2'd1; end
                8'h1C:   begin w_dec_hit = 1'b1; w_dec_move = 2'd2; end
                8'h1B:   begin w_dec_hit = 1'b1; w_dec_move = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tocnt    <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            scan_code  <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            move       <= 2'd0;
            move_valid <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            move_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                r_tocnt <= '0;
                if (w_fall && !r_d_s2) begin
                    r_state  <= S_DATA;
                    r_bitcnt <= '0;
                end
            end else if (w_fall) begin
                r_tocnt <= '0;
                case (r_state)
                    S_DATA: begin
                        r_shift  <= {r_d_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= r_d_s2;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (r_d_s2 && (^{r_shift, r_par})) begin
                            scan_code  <= r_shift;
                            code_valid <= 1'b1;
                            if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                                if (!r_brk && w_dec_hit) begin
                                    move       <= w_dec_move;
                                    move_valid <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_ext     <= 1'b0;
                            r_brk     <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // device stalled mid-frame: drop the partial byte and resync
                r_state   <= S_IDLE;
                r_tocnt   <= '0;
                r_shift   <= '0;
                frame_err <= 1'b1;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
            end else begin
                r_tocnt <= r_tocnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ps2_move_rx.sv
// Scoreboarded bench for ps2_move_rx: each frame sent pushes its expected
// code/error event; a monitor pops and checks every pulse the receiver emits.
module tb_ps2_move_rx;
    localparam int TIMEOUT = 10_000;
    localparam int HALF    = 30;

    typedef struct packed {
        logic [7:0] code;
        logic       err;
        logic       mv_vld;
        logic [1:0] mv;
    } exp_t;

    logic       mclk;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic [1:0] move;
    logic       move_valid;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ps2_move_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .move       (move),
        .move_valid (move_valid)
    );

    initial begin
        mclk = 1'b0;
        forever #10 mclk = ~mclk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: every pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge mclk);
            if (code_valid && frame_err) begin
                n_tests++; n_fail++;
                $display("FAIL exclusive: code_valid and frame_err both high");
            end
            if (move_valid && !code_valid) begin
                n_tests++; n_fail++;
                $display("FAIL move_valid_alone: move_valid=1 without code_valid");
            end
            if (code_valid || frame_err) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: code_valid=%0b frame_err=%0b scan_code=%02h", code_valid, frame_err, scan_code);
                end else begin
                    e = q.pop_front();
                    if (frame_err !== e.err) begin
                        n_fail++;
                        $display("FAIL event_kind: frame_err=%0b expected %0b (scan_code=%02h)", frame_err, e.err, scan_code);
                    end
                    n_tests++;
                    if (scan_code !== e.code) begin
                        n_fail++;
                        $display("FAIL scan_code: got %02h expected %02h", scan_code, e.code);
                    end
                    n_tests++;
                    if (move_valid !== e.mv_vld) begin
                        n_fail++;
                        $display("FAIL move_valid: got %0b expected %0b (code %02h)", move_valid, e.mv_vld, e.code);
                    end
                    n_tests++;
                    if (move !== e.mv) begin
                        n_fail++;
                        $display("FAIL move: got %0d expected %0d (code %02h)", move, e.mv, e.code);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic push_code(input logic [7:0] c, input logic mv_vld, input logic [1:0] mv);
        q.push_back('{code: c, err: 1'b0, mv_vld: mv_vld, mv: mv});
    endtask

    task automatic push_err(input logic [7:0] held_code, input logic [1:0] mv);
        q.push_back('{code: held_code, err: 1'b1, mv_vld: 1'b0, mv: mv});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop_bit, (bad_par ? ^b : ~^b), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            ps2c = 1'b1;
            if (glitch) begin
                cyc(14); ps2c = 1'b0; cyc(3); ps2c = 1'b1; cyc(13);
            end else begin
                cyc(HALF);
            end
            ps2c = 1'b0;
            if (glitch) begin
                cyc(16); ps2c = 1'b1; cyc(3); ps2c = 1'b0; cyc(11);
            end else begin
                cyc(HALF);
            end
        end
        ps2c = 1'b1;
        ps2d = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            cyc(1);
            k++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: %0d expected events not seen", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_tests++;
        if (scan_code !== 8'h00) begin n_fail++; $display("FAIL %s_scan_code: got %02h expected 00", name, scan_code); end
        n_tests++;
        if (code_valid !== 1'b0) begin n_fail++; $display("FAIL %s_code_valid: got %0b expected 0", name, code_valid); end
        n_tests++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL %s_frame_err: got %0b expected 0", name, frame_err); end
        n_tests++;
        if (move !== 2'd0) begin n_fail++; $display("FAIL %s_move: got %0d expected 0", name, move); end
        n_tests++;
        if (move_valid !== 1'b0) begin n_fail++; $display("FAIL %s_move_valid: got %0b expected 0", name, move_valid); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        cyc(5);
        check_outputs_zero("reset");
        reset = 1'b0;
        cyc(20);
    endtask

    task automatic test_make_w();
        push_code(8'h1D, 1'b1, 2'd1);
        send(8'h1D);
        wait_drain("make_w");
    endtask

    task automatic test_extended();
        push_code(8'hE0, 1'b0, 2'd1);
        push_code(8'h6B, 1'b1, 2'd2);
        send(8'hE0);
        send(8'h6B);
        wait_drain("extended");
    endtask

    task automatic test_break();
        push_code(8'hF0, 1'b0, 2'd2);
        push_code(8'h1B, 1'b0, 2'd2);
        push_code(8'h1B, 1'b1, 2'd3);
        send(8'hF0);
        send(8'h1B);
        send(8'h1B);
        wait_drain("break");
    endtask

    task automatic test_frame_err();
        // E0 pending when the bad frame arrives; the error must drop it
        push_code(8'hE0, 1'b0, 2'd3);
        push_err(8'hE0, 2'd3);
        push_code(8'h6B, 1'b0, 2'd3);
        push_err(8'h6B, 2'd3);
        push_code(8'h23, 1'b1, 2'd0);
        send(8'hE0);
        send_frame(8'h23, 1'b1, 1'b1, 11, 1'b0);
        send(8'h6B);
        send_frame(8'h23, 1'b0, 1'b0, 11, 1'b0);
        send(8'h23);
        wait_drain("frame_err");
    endtask

    task automatic test_timeout();
        push_code(8'hE0, 1'b0, 2'd0);
        push_err(8'hE0, 2'd0);
        push_code(8'h74, 1'b0, 2'd0);
        send(8'hE0);
        send_frame(8'h74, 1'b0, 1'b1, 6, 1'b0);
        cyc(TIMEOUT + 10);
        send(8'h74);
        wait_drain("timeout");
    endtask

    task automatic test_glitch();
        push_code(8'h1C, 1'b1, 2'd2);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
        wait_drain("glitch");
    endtask

    task automatic test_back_to_back();
        push_code(8'hE0, 1'b0, 2'd2);
        push_code(8'hF0, 1'b0, 2'd2);
        push_code(8'h74, 1'b0, 2'd2);
        push_code(8'h75, 1'b0, 2'd2);
        push_code(8'h1D, 1'b1, 2'd1);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        send(8'h75);
        send(8'h1D);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 4, 1'b0);
        ps2c  = 1'b0;
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        ps2c = 1'b1;
        cyc(10);
        reset = 1'b0;
        cyc(100);
        push_code(8'h1B, 1'b1, 2'd3);
        send(8'h1B);
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_make_w();
        test_extended();
        test_break();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        cyc(50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
